// File: rtl/dma_rd_arbiter_if.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : dma_rd_arbiter_if
// Brief    : Requester-side and DMA-engine-side signal bundle for dma_rd_arbiter.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
interface dma_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int AXI_DATA_W = 128,
    parameter int AXI_ADDR_W = 32
);
    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*AXI_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*24-1:0]         req_len;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [AXI_DATA_W-1:0]         rsp_data;
    logic                          rsp_last;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic                          busy;

    // DMA read engine side
    logic                          dma_cmd_valid;
    logic                          dma_cmd_ready;
    logic [AXI_ADDR_W-1:0]         dma_cmd_addr;
    logic [23:0]                   dma_cmd_len;
    logic [3:0]                    dma_cmd_tag;
    logic                          dma_data_valid;
    logic                          dma_data_ready;
    logic [AXI_DATA_W-1:0]         dma_data;
    logic                          dma_data_last;
    logic [3:0]                    dma_data_tag;
    logic                          dma_done;
    logic                          dma_error;

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        input  dma_cmd_ready, dma_data_valid, dma_data, dma_data_last,
        input  dma_data_tag, dma_done, dma_error,
        output req_ready, rsp_valid, rsp_data, rsp_last, req_done, req_err, busy,
        output dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_cmd_tag, dma_data_ready
    );

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        output dma_cmd_ready, dma_data_valid, dma_data, dma_data_last,
        output dma_data_tag, dma_done, dma_error,
        input  req_ready, rsp_valid, rsp_data, rsp_last, req_done, req_err, busy,
        input  dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_cmd_tag, dma_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/dma_rd_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : dma_rd_arbiter
// Brief    : Round-robin arbiter sharing one DMA read engine among NUM_REQ
//            requesters, one transfer in flight. Define DMA_ARB_PRIO0_EN to
//            give requester 0 strict priority.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
module dma_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int AXI_DATA_W = 128,
    parameter int AXI_ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dma_rd_arbiter_if.slave bus
);
    localparam int c_LEN_W = 24;
    localparam int c_TAG_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_TAG_W-1:0]    r_rr_ptr;
    logic [c_TAG_W-1:0]    r_gnt;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [c_LEN_W-1:0]    r_len;
    logic                  r_mismatch;
    logic                  r_cmd_valid;
    logic                  r_busy;
    logic [NUM_REQ-1:0]    r_req_done;
    logic [NUM_REQ-1:0]    r_req_err;

    logic [2*NUM_REQ-1:0]  w_rot_dbl;
    logic [NUM_REQ-1:0]    w_rot;
    logic                  w_pick_found;
    logic [c_TAG_W:0]      w_pick_off;
    logic [c_TAG_W:0]      w_pick_sum;
    logic [c_TAG_W-1:0]    w_pick_rr;
    logic [c_TAG_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]    w_pick_oh;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic [AXI_ADDR_W-1:0] w_pick_addr;
    logic [c_LEN_W-1:0]    w_pick_len;
    logic [c_TAG_W-1:0]    w_ptr_next;
    logic                  w_in_xfer;
    logic                  w_beat_hs;
    logic                  w_tag_bad;
    logic                  w_err;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_rot_dbl = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
    assign w_rot     = w_rot_dbl[NUM_REQ-1:0];

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pick_found = 1'b1;
                w_pick_off   = (c_TAG_W + 1)'(i);
            end
        end
    end

    assign w_pick_sum = {1'b0, r_rr_ptr} + w_pick_off;
    assign w_pick_rr  = (w_pick_sum >= (c_TAG_W + 1)'(NUM_REQ))
                        ? c_TAG_W'(w_pick_sum - (c_TAG_W + 1)'(NUM_REQ))
                        : c_TAG_W'(w_pick_sum);

`ifdef DMA_ARB_PRIO0_EN
    assign w_pick_idx = bus.req_valid[0] ? '0 : w_pick_rr;
`else
    assign w_pick_idx = w_pick_rr;
`endif

    always_comb begin
        w_pick_addr = '0;
        w_pick_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == c_TAG_W'(i)) begin
                w_pick_addr = bus.req_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
                w_pick_len  = bus.req_len[i*c_LEN_W +: c_LEN_W];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign w_pick_oh[gi] = w_pick_found && (w_pick_idx == c_TAG_W'(gi));
        assign w_gnt_oh[gi]  = (r_gnt == c_TAG_W'(gi));
    end

    assign w_ptr_next = (r_gnt == c_TAG_W'(NUM_REQ - 1)) ? '0 : r_gnt + c_TAG_W'(1);
    assign w_in_xfer  = (r_state == S_XFER);
    assign w_beat_hs  = w_in_xfer && bus.dma_data_valid && bus.dma_data_ready;
    assign w_tag_bad  = w_beat_hs && (bus.dma_data_tag != r_gnt);
    // A bad tag on the very beat that coincides with dma_done must still count.
    assign w_err      = bus.dma_error || r_mismatch || w_tag_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_mismatch  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_done  <= '0;
            r_req_err   <= '0;
        end else begin
            r_req_done <= '0;
            r_req_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_gnt       <= w_pick_idx;
                        r_addr      <= w_pick_addr;
                        r_len       <= w_pick_len;
                        r_cmd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.dma_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_tag_bad) begin
                        r_mismatch <= 1'b1;
                    end
                    if (bus.dma_done) begin
                        r_req_done <= w_gnt_oh;
                        r_req_err  <= w_err ? w_gnt_oh : '0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_mismatch <= 1'b0;
                    r_busy     <= 1'b0;
`ifdef DMA_ARB_PRIO0_EN
                    if (r_gnt != '0) begin
                        r_rr_ptr <= w_ptr_next;
                    end
`else
                    r_rr_ptr <= w_ptr_next;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready      = (r_state == S_IDLE) ? w_pick_oh : '0;
    assign bus.dma_cmd_valid  = r_cmd_valid;
    assign bus.dma_cmd_addr   = r_addr;
    assign bus.dma_cmd_len    = r_len;
    assign bus.dma_cmd_tag    = r_gnt;
    assign bus.rsp_valid      = (w_in_xfer && bus.dma_data_valid) ? w_gnt_oh : '0;
    assign bus.dma_data_ready = w_in_xfer && |(bus.rsp_ready & w_gnt_oh);
    assign bus.rsp_data       = bus.dma_data;
    assign bus.rsp_last       = bus.dma_data_last;
    assign bus.req_done       = r_req_done;
    assign bus.req_err        = r_req_err;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_arbiter.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// Module   : tb_dma_rd_arbiter
// Brief    : Scoreboard bench for dma_rd_arbiter with a directed engine model.
// Revision : 1.0
//////////////////////////////////////////////////////////////////////////////
module tb_dma_rd_arbiter;
    localparam int NR = 4;
    localparam int DW = 128;
    localparam int AW = 32;

    typedef struct { int idx; logic [AW-1:0] addr; logic [23:0] len; } cmd_t;
    typedef struct { int idx; logic [DW-1:0] data; bit last; } beat_t;
    typedef struct { int idx; bit err; } done_t;

    logic clk;
    logic rst_n;

    dma_rd_arbiter_if #(.NUM_REQ(NR), .AXI_DATA_W(DW), .AXI_ADDR_W(AW)) bus ();

    dma_rd_arbiter #(.NUM_REQ(NR), .AXI_DATA_W(DW), .AXI_ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    int    cyc      = 0;
    int    grant_cyc = -10;
    bit    prev_cv  = 1'b0;
    int    exp_grant[$];
    cmd_t  exp_cmd[$];
    beat_t exp_beat[$];
    done_t exp_done[$];
    string tmo_q[$];

    function automatic logic [DW-1:0] mk_data(input int tag, input int b);
        return {24'hDA7A00, tag[3:0], b[3:0], 96'hFEED0000CAFE0000BEEF0000};
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    // Scoreboard monitor: every DUT output event pops its expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk(bus.req_ready == '0, "rst_req_ready", 128'(bus.req_ready), 0);
            chk(bus.rsp_valid == '0, "rst_rsp_valid", 128'(bus.rsp_valid), 0);
            chk(bus.req_done == '0, "rst_req_done", 128'(bus.req_done), 0);
            chk(bus.req_err == '0, "rst_req_err", 128'(bus.req_err), 0);
            chk(bus.dma_cmd_valid == 1'b0, "rst_cmd_valid", 128'(bus.dma_cmd_valid), 0);
            chk(bus.dma_data_ready == 1'b0, "rst_data_ready", 128'(bus.dma_data_ready), 0);
            chk(bus.busy == 1'b0, "rst_busy", 128'(bus.busy), 0);
        end else begin
            cyc++;
            while (tmo_q.size() > 0) chk(1'b0, tmo_q.pop_front(), 0, 1);

            if (bus.req_ready != '0) begin
                if (exp_grant.size() == 0) begin
                    chk(bus.req_ready == '0, "grant_unexpected", 128'(bus.req_ready), 0);
                end else begin
                    int g;
                    g = exp_grant.pop_front();
                    chk(bus.req_ready == onehot(g), "grant_order", 128'(bus.req_ready), 128'(onehot(g)));
                end
                grant_cyc = cyc;
            end

            if (bus.dma_cmd_valid && !prev_cv)
                chk(cyc == grant_cyc + 1, "grant_to_cmd_latency", 128'(cyc), 128'(grant_cyc + 1));
            prev_cv = bus.dma_cmd_valid;

            if (bus.dma_cmd_valid && bus.dma_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    chk(1'b0, "cmd_unexpected", 128'(bus.dma_cmd_tag), 0);
                end else begin
                    cmd_t c;
                    c = exp_cmd.pop_front();
                    chk(bus.dma_cmd_addr == c.addr && bus.dma_cmd_len == c.len &&
                        bus.dma_cmd_tag == 4'(c.idx), "cmd_fields",
                        {bus.dma_cmd_addr, bus.dma_cmd_len, bus.dma_cmd_tag},
                        {c.addr, c.len, 4'(c.idx)});
                end
            end

            if (bus.rsp_valid != '0) begin
                if (exp_beat.size() == 0) begin
                    chk(bus.rsp_valid == '0, "beat_unexpected", 128'(bus.rsp_valid), 0);
                end else begin
                    beat_t e;
                    e = exp_beat[0];
                    chk(bus.rsp_valid == onehot(e.idx), "rsp_valid_route",
                        128'(bus.rsp_valid), 128'(onehot(e.idx)));
                    chk(bus.dma_data_ready == |(bus.rsp_ready & onehot(e.idx)), "data_ready_mirror",
                        128'(bus.dma_data_ready), 128'(|(bus.rsp_ready & onehot(e.idx))));
                    if (|(bus.rsp_valid & bus.rsp_ready)) begin
                        void'(exp_beat.pop_front());
                        chk(bus.rsp_data == e.data, "beat_data", bus.rsp_data, e.data);
                        chk(bus.rsp_last == e.last, "beat_last", 128'(bus.rsp_last), 128'(e.last));
                    end
                end
            end

            if (bus.req_done != '0) begin
                if (exp_done.size() == 0) begin
                    chk(bus.req_done == '0, "done_unexpected", 128'(bus.req_done), 0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk(bus.req_done == onehot(d.idx), "req_done", 128'(bus.req_done), 128'(onehot(d.idx)));
                    chk(bus.req_err == (d.err ? onehot(d.idx) : '0), "req_err",
                        128'(bus.req_err), 128'(d.err ? onehot(d.idx) : '0));
                end
            end else if (bus.req_err != '0) begin
                chk(bus.req_err == '0, "err_without_done", 128'(bus.req_err), 0);
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [23:0] l);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_len[i*24 +: 24]  = l;
    endtask

    task automatic expect_xfer(input int i, input logic [AW-1:0] a, input logic [23:0] l, input bit err);
        int nb;
        nb = int'(l) / (DW / 8);
        exp_grant.push_back(i);
        exp_cmd.push_back('{i, a, l});
        for (int b = 0; b < nb; b++) exp_beat.push_back('{i, mk_data(i, b), b == nb - 1});
        exp_done.push_back('{i, err});
    endtask

    // Requester i keeps req_valid high until it has been granted cnt[i] times.
    task automatic drive_reqs(input int c0, input int c1, input int c2, input int c3);
        int cnt[NR];
        logic [NR-1:0] g;
        int k;
        cnt = '{c0, c1, c2, c3};
        for (int i = 0; i < NR; i++) bus.req_valid[i] = (cnt[i] > 0);
        k = 0;
        while (bus.req_valid != '0 && k < 1000) begin
            @(negedge clk);
            g = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) bus.req_valid[i] = 1'b0;
                end
            end
            k++;
        end
        if (bus.req_valid != '0) begin
            tmo_q.push_back("requester_timeout");
            bus.req_valid = '0;
        end
    endtask

    // Engine model: accept n commands, stream len/16 beats each, pulse done.
    task automatic engine_run(input int n, input int err_mask, input int bad_mask, input bit tgl);
        for (int x = 0; x < n; x++) begin
            int tag, nb, k;
            bit hs;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!bus.dma_cmd_valid && k < 100);
            if (!bus.dma_cmd_valid) begin
                tmo_q.push_back("engine_cmd_timeout");
                return;
            end
            tag = int'(bus.dma_cmd_tag);
            nb  = int'(bus.dma_cmd_len) / (DW / 8);
            @(posedge clk); #1 bus.dma_cmd_ready = 1'b1;
            @(posedge clk); #1 bus.dma_cmd_ready = 1'b0;
            if (tgl) bus.rsp_ready[1] = 1'b0;
            for (int b = 0; b < nb; b++) begin
                bus.dma_data_valid = 1'b1;
                bus.dma_data       = mk_data(tag, b);
                bus.dma_data_last  = (b == nb - 1);
                bus.dma_data_tag   = bad_mask[x] ? 4'd5 : 4'(tag);
                hs = 1'b0;
                k  = 0;
                while (!hs && k < 50) begin
                    @(negedge clk);
                    hs = bus.dma_data_ready;
                    @(posedge clk);
                    #1;
                    if (tgl) bus.rsp_ready[1] = ~bus.rsp_ready[1];
                    k++;
                end
                if (!hs) tmo_q.push_back("engine_beat_timeout");
            end
            bus.dma_data_valid = 1'b0;
            bus.dma_data_last  = 1'b0;
            bus.rsp_ready      = '1;
            bus.dma_error      = err_mask[x];
            bus.dma_done       = 1'b1;
            @(posedge clk); #1 bus.dma_done = 1'b0;
            @(posedge clk); #1 bus.dma_error = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_grant.size() + exp_cmd.size() + exp_beat.size() + exp_done.size() != 0 ||
                bus.busy) && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (exp_grant.size() + exp_cmd.size() + exp_beat.size() + exp_done.size() != 0 || bus.busy)
            tmo_q.push_back({"drain_timeout_", nm});
        exp_grant.delete();
        exp_cmd.delete();
        exp_beat.delete();
        exp_done.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_len = '0; bus.rsp_ready = '1;
        bus.dma_cmd_ready = 1'b0; bus.dma_data_valid = 1'b0; bus.dma_data = '0;
        bus.dma_data_last = 1'b0; bus.dma_data_tag = '0; bus.dma_done = 1'b0; bus.dma_error = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // dma_done while idle must not produce any completion
        @(posedge clk); #1 bus.dma_done = 1'b1;
        @(posedge clk); #1 bus.dma_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // all four requesting at once: 0,1,2,3 and the pointer wraps to 0
        for (int i = 0; i < NR; i++) set_req(i, AW'(32'h100 * (i + 1)), 24'd16);
        for (int i = 0; i < NR; i++) expect_xfer(i, AW'(32'h100 * (i + 1)), 24'd16, 1'b0);
        fork
            drive_reqs(1, 1, 1, 1);
            engine_run(4, 0, 0, 1'b0);
        join
        drain("all_four");

        // requesters 0 and 1 held continuously for two grants each
`ifdef DMA_ARB_PRIO0_EN
        expect_xfer(0, 32'h100, 24'd16, 1'b0);
        expect_xfer(0, 32'h100, 24'd16, 1'b0);
        expect_xfer(1, 32'h200, 24'd16, 1'b0);
        expect_xfer(1, 32'h200, 24'd16, 1'b0);
`else
        expect_xfer(0, 32'h100, 24'd16, 1'b0);
        expect_xfer(1, 32'h200, 24'd16, 1'b0);
        expect_xfer(0, 32'h100, 24'd16, 1'b0);
        expect_xfer(1, 32'h200, 24'd16, 1'b0);
`endif
        fork
            drive_reqs(2, 2, 0, 0);
            engine_run(4, 0, 0, 1'b0);
        join
        drain("pair");

        // single request, four beats
        set_req(2, 32'h1000, 24'd64);
        expect_xfer(2, 32'h1000, 24'd64, 1'b0);
        fork
            drive_reqs(0, 0, 1, 0);
            engine_run(1, 0, 0, 1'b0);
        join
        drain("single");

        // rsp_ready[1] toggling throughout a four-beat transfer
        set_req(1, 32'h2000, 24'd64);
        expect_xfer(1, 32'h2000, 24'd64, 1'b0);
        fork
            drive_reqs(0, 1, 0, 0);
            engine_run(1, 0, 0, 1'b1);
        join
        drain("backpressure");

        // zero-length command
        set_req(3, 32'h3000, 24'd0);
        expect_xfer(3, 32'h3000, 24'd0, 1'b0);
        fork
            drive_reqs(0, 0, 0, 1);
            engine_run(1, 0, 0, 1'b0);
        join
        drain("zero_len");

        // engine error on requester 3, then a clean transfer on requester 0
        set_req(3, 32'h3400, 24'd32);
        expect_xfer(3, 32'h3400, 24'd32, 1'b1);
        fork
            drive_reqs(0, 0, 0, 1);
            engine_run(1, 1, 0, 1'b0);
        join
        drain("dma_error");
        set_req(0, 32'h4000, 24'd16);
        expect_xfer(0, 32'h4000, 24'd16, 1'b0);
        fork
            drive_reqs(1, 0, 0, 0);
            engine_run(1, 0, 0, 1'b0);
        join
        drain("after_error");

        // wrong tag on a beat: forwarded, reported as error at completion
        set_req(2, 32'h5000, 24'd16);
        expect_xfer(2, 32'h5000, 24'd16, 1'b1);
        fork
            drive_reqs(0, 0, 1, 0);
            engine_run(1, 0, 1, 1'b0);
        join
        drain("tag_mismatch");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dma_rd_arbiter.md
DMA_RD_ARBITER -- requirements
Module: dma_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the DMA read engine (legal 2..16).
REQ-002 Parameter AXI_DATA_W, default 128, data beat width in bits.
REQ-003 Parameter AXI_ADDR_W, default 32, byte address width.
REQ-004 Port clk  input  1  clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port req_valid  input  NUM_REQ  per-requester read request.
REQ-007 Port req_ready  output  NUM_REQ  one-hot request accept.
REQ-008 Port req_addr  input  NUM_REQ*AXI_ADDR_W  flattened start addresses; slice i = requester i.
REQ-009 Port req_len  input  NUM_REQ*24  flattened byte counts.
REQ-010 Port dma_cmd_valid / dma_cmd_ready  output / input  1 / 1  command handshake to the DMA read engine.
REQ-011 Port dma_cmd_addr / dma_cmd_len / dma_cmd_tag  output  AXI_ADDR_W / 24 / 4  command fields; tag = granted index.
REQ-012 Port dma_data_valid / dma_data_ready  input / output  1 / 1  data stream from the engine.
REQ-013 Port dma_data / dma_data_last / dma_data_tag  input  AXI_DATA_W / 1 / 4  beat payload, last-of-transfer, tag.
REQ-014 Port dma_done / dma_error  input  1 / 1  engine completion pulse, sticky error.
REQ-015 Port rsp_valid / rsp_ready  output / input  NUM_REQ / NUM_REQ  per-requester data handshake.
REQ-016 Port rsp_data / rsp_last  output  AXI_DATA_W / 1  shared payload; dma_data and dma_data_last passed through.
REQ-017 Port req_done / req_err  output  NUM_REQ / NUM_REQ  one-cycle completion and error pulses.
REQ-018 Port busy  output  1  high whenever state != S_IDLE.

Function
REQ-019 FSM states S_IDLE, S_ISSUE, S_XFER, S_DONE; exactly one transfer in flight.
REQ-020 S_IDLE: if any req_valid, grant via round-robin starting at rr_ptr, drive req_ready[g]=1 combinationally that cycle, latch addr, len and g, go to S_ISSUE.
REQ-021 S_ISSUE: dma_cmd_valid=1 with the latched fields; on dma_cmd_ready go to S_XFER; fields stay stable until accepted.
REQ-022 Grant-to-dma_cmd_valid latency is exactly 1 cycle.
REQ-023 S_XFER: rsp_valid[g]=dma_data_valid, rsp_valid of all other requesters = 0, dma_data_ready=rsp_ready[g]; combinational, zero added latency.
REQ-024 S_XFER: a beat with dma_data_tag != g sets an internal mismatch flag; the beat is still forwarded.
REQ-025 S_XFER: on dma_done go to S_DONE, including zero-length commands, where no beats arrive.
REQ-026 S_DONE: req_done[g]=1 for one cycle; req_err[g]=dma_error OR mismatch flag; rr_ptr <= (g+1) mod NUM_REQ; mismatch flag cleared; next state S_IDLE.
REQ-027 A request asserted during S_ISSUE, S_XFER or S_DONE is not accepted until S_IDLE; req_valid must hold until req_ready.
REQ-028 Round-robin: lowest index at or cyclically after rr_ptr wins; with all NUM_REQ valid, grants rotate 0,1,2,3,0...
REQ-029 rr_ptr wraps from NUM_REQ-1 to 0.
REQ-030 dma_done outside S_XFER is ignored.
REQ-031 Minimum back-to-back spacing is 1 idle cycle between req_done and the next req_ready.

Reset
REQ-032 rst_n low forces S_IDLE, rr_ptr=0, mismatch flag=0, and latched fields=0.
REQ-033 Reset values: req_ready, rsp_valid, req_done, req_err, dma_cmd_valid, dma_data_ready and busy are 0.
REQ-034 Reset mid-transfer abandons the transfer with no req_done; the DMA engine shares rst_n.

Configuration
REQ-035 Macro DMA_ARB_PRIO0_EN: when defined, requester 0 has strict priority over round-robin whenever req_valid[0]=1, and rr_ptr is not updated on requester-0 grants.
REQ-036 Without DMA_ARB_PRIO0_EN, pure round-robin per REQ-028 applies.

Verification
REQ-037 Single req: req_valid[2], addr 0x1000, len 64 -> req_ready[2] at grant; dma_cmd_tag=2 next cycle; 4 beats on rsp_valid[2] only; req_done[2] pulse; req_err=0.
REQ-038 All four held valid, len 16 each -> grant order 0,1,2,3,0; rr_ptr wraps.
REQ-039 rsp_ready[1] toggling 1/0 during a 4-beat transfer -> dma_data_ready mirrors it; no beat lost or duplicated.
REQ-040 len 0 -> command issued; no rsp_valid; dma_done gives req_done pulse; return to S_IDLE.
REQ-041 dma_error=1 at done for requester 3 -> req_err[3] pulse; next grant proceeds normally.
REQ-042 With DMA_ARB_PRIO0_EN, req 0 and req 1 valid continuously -> req 0 granted every time; macro undefined -> alternate 0,1.
